// File: rtl/mdu_seq.sv
// mdu_seq: EX-stage sequencer for MULT/MULTU/DIV/DIVU.
// Drives a pipelined multiplier (fixed MUL_LAT) and an iterative divider
// (start/ready/annul), stalls EX until {hi,lo} is ready, absorbs flush,
// divide-by-zero and divider timeout.
// Optional: define MDU_FAST_DIV_EN to bypass the divider for trivial divides
// (divisor 1, DIV by -1, zero dividend).
module mdu_seq #(
  parameter int unsigned MUL_LAT     = 2,
  parameter int unsigned DIV_TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] src_a_i,
  input  logic [31:0] src_b_i,
  input  logic        flush_i,
  input  logic        ex_advance_i,
  output logic        stallreq_o,
  output logic        res_valid_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        err_timeout_o,
  output logic        mul_signed_o,
  output logic [31:0] mul_a_o,
  output logic [31:0] mul_b_o,
  input  logic [63:0] mul_result_i,
  output logic        div_start_o,
  output logic        div_signed_o,
  output logic [31:0] div_opdata1_o,
  output logic [31:0] div_opdata2_o,
  output logic        div_annul_o,
  input  logic        div_ready_i,
  input  logic [63:0] div_result_i
);

  localparam int unsigned TW       = $clog2(DIV_TIMEOUT + 1);
  localparam logic [2:0]  MUL_LAST = 3'(MUL_LAT);
  localparam logic [TW-1:0] DIV_LAST = TW'(DIV_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT, DONE} state_t;

  state_t        state;
  logic [2:0]    cnt;
  logic [TW-1:0] tcnt;
  logic [31:0]   a_q, b_q, hi_q, lo_q;
  logic          sgn_q, err_q;

  logic        in_wait, kill, take, mul_issue, div_kill, div_tmo;
  logic        div_bypass;
  logic [63:0] bypass_res;

  assign in_wait   = (state == MUL_WAIT) || (state == DIV_WAIT);
  // Losing op_valid_i mid-operation is handled exactly like a flush.
  assign kill      = flush_i | (in_wait & ~op_valid_i);
  assign take      = (state == IDLE) & op_valid_i & ~flush_i;
  assign mul_issue = take & ~op_i[1];
  assign div_kill  = (state == DIV_WAIT) & kill;
  assign div_tmo   = (state == DIV_WAIT) & ~kill & ~div_ready_i & (tcnt == DIV_LAST);

  // Divides resolved without the divider (divide-by-zero always, trivial ones optionally)
  always_comb begin
    div_bypass = (src_b_i == '0);
    bypass_res = {src_a_i, 32'hFFFF_FFFF};
`ifdef MDU_FAST_DIV_EN
    if (src_b_i == '0) begin
      div_bypass = 1'b1;
    end else if (src_b_i == 32'd1) begin
      div_bypass = 1'b1;
      bypass_res = {32'd0, src_a_i};
    end else if (!op_i[0] && (src_b_i == '1)) begin
      div_bypass = 1'b1;
      bypass_res = {32'd0, 32'(-src_a_i)};
    end else if (src_a_i == '0) begin
      div_bypass = 1'b1;
      bypass_res = '0;
    end
`endif
  end

  assign stallreq_o    = op_valid_i & (state != DONE) & ~flush_i;
  assign res_valid_o   = (state == DONE);
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;
  assign err_timeout_o = err_q;

  // The multiplier sees operands straight from src in the issue cycle so its
  // latency counts from IDLE; afterwards the latched copies keep them stable.
  assign mul_signed_o  = mul_issue ? ~op_i[0] : ((state == MUL_WAIT) & sgn_q);
  assign mul_a_o       = mul_issue ? src_a_i : ((state == MUL_WAIT) ? a_q : '0);
  assign mul_b_o       = mul_issue ? src_b_i : ((state == MUL_WAIT) ? b_q : '0);

  assign div_start_o   = (state == DIV_WAIT) & ~kill & ~div_ready_i & (tcnt != DIV_LAST);
  assign div_signed_o  = (state == DIV_WAIT) & sgn_q;
  assign div_opdata1_o = (state == DIV_WAIT) ? a_q : '0;
  assign div_opdata2_o = (state == DIV_WAIT) ? b_q : '0;
  assign div_annul_o   = div_kill | div_tmo;

  // Sequencer: operand capture, latency/timeout counting, result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      tcnt  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      sgn_q <= 1'b0;
      hi_q  <= '0;
      lo_q  <= '0;
      err_q <= 1'b0;
    end else if (kill) begin
      state <= IDLE;
      cnt   <= '0;
      tcnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            a_q   <= src_a_i;
            b_q   <= src_b_i;
            sgn_q <= ~op_i[0];
            cnt   <= 3'd1;
            tcnt  <= '0;
            if (!op_i[1]) begin
              state <= MUL_WAIT;
            end else if (div_bypass) begin
              {hi_q, lo_q} <= bypass_res;
              state        <= DONE;
            end else begin
              state <= DIV_WAIT;
            end
          end
        end
        MUL_WAIT: begin
          if (cnt == MUL_LAST) begin
            {hi_q, lo_q} <= mul_result_i;
            state        <= DONE;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        DIV_WAIT: begin
          if (div_ready_i) begin
            {hi_q, lo_q} <= div_result_i;
            state        <= DONE;
          end else if (tcnt == DIV_LAST) begin
            err_q <= 1'b1;
            hi_q  <= '0;
            lo_q  <= '0;
            state <= DONE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        DONE: begin
          if (ex_advance_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Testbench for mdu_seq: behavioural multiplier/divider models, scoreboard
// queue of expected {hi,lo}, one checking task for every comparison.
module tb_mdu_seq;

  localparam int ML = 2;
  localparam int TO = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid, flush, ex_advance;
  logic [1:0]  op_in;
  logic [31:0] src_a, src_b;
  logic        stallreq, res_valid, err_timeout;
  logic [31:0] hi, lo;
  logic        mul_signed, div_start, div_signed, div_annul;
  logic [31:0] mul_a, mul_b, div_op1, div_op2;
  logic [63:0] mul_result, div_result;
  logic        div_ready, ready_m, ready_force;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];
  int div_delay = 1000;
  int dcnt = 0;
  logic [63:0] mpipe [ML];

  always #5 clk = ~clk;

  mdu_seq #(.MUL_LAT(ML), .DIV_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .op_valid_i(op_valid), .op_i(op_in),
    .src_a_i(src_a), .src_b_i(src_b), .flush_i(flush), .ex_advance_i(ex_advance),
    .stallreq_o(stallreq), .res_valid_o(res_valid), .hi_o(hi), .lo_o(lo),
    .err_timeout_o(err_timeout), .mul_signed_o(mul_signed), .mul_a_o(mul_a),
    .mul_b_o(mul_b), .mul_result_i(mul_result), .div_start_o(div_start),
    .div_signed_o(div_signed), .div_opdata1_o(div_op1), .div_opdata2_o(div_op2),
    .div_annul_o(div_annul), .div_ready_i(div_ready), .div_result_i(div_result)
  );

  function automatic logic [63:0] golden_mul(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    logic signed [63:0] sa, sb;
    if (sgn) begin
      sa = $signed({{32{a[31]}}, a});
      sb = $signed({{32{b[31]}}, b});
      return 64'(sa * sb);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  function automatic logic [63:0] golden_div(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    logic [31:0] q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Pipelined multiplier: result ML cycles after operands are presented
  always @(posedge clk) begin
    mpipe[0] <= golden_mul(mul_a, mul_b, mul_signed);
    for (int i = 1; i < ML; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_result = mpipe[ML-1];

  // Iterative divider: ready pulse after div_delay cycles of continuous start
  always @(posedge clk) begin
    ready_m <= 1'b0;
    if (rst || !div_start || div_annul) begin
      dcnt <= 0;
    end else if (dcnt + 1 == div_delay) begin
      ready_m    <= 1'b1;
      div_result <= golden_div(div_op1, div_op2, div_signed);
      dcnt       <= 0;
    end else begin
      dcnt <= dcnt + 1;
    end
  end
  assign div_ready = ready_m | ready_force;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op, wait (bounded) for res_valid, compare against the scoreboard
  task automatic do_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] e, input int dly,
                       input int hold, input int exp_stall, input int exp_start,
                       input int exp_annul);
    logic [63:0] r;
    int st, ss, an;
    bit got;
    exp_q.push_back(e);
    div_delay = dly;
    @(negedge clk);
    op_valid = 1'b1; op_in = op; src_a = a; src_b = b; ex_advance = 1'b0;
    st = 0; ss = 0; an = 0; got = 0;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (res_valid) begin got = 1; break; end
      if (stallreq)  st++;
      if (div_start) ss++;
      if (div_annul) an++;
      @(negedge clk);
      src_a = $urandom; src_b = $urandom;
    end
    check({nm, ".done"}, 64'(got), 64'd1);
    r = exp_q.pop_front();
    check({nm, ".hilo"}, {hi, lo}, r);
    check({nm, ".stall_cycles"}, 64'(st), 64'(exp_stall));
    check({nm, ".start_cycles"}, 64'(ss), 64'(exp_start));
    check({nm, ".annul_cycles"}, 64'(an), 64'(exp_annul));
    check({nm, ".stall_in_done"}, 64'(stallreq), 64'd0);
    repeat (hold) begin
      @(negedge clk); #1;
      check({nm, ".hold_valid"}, 64'(res_valid), 64'd1);
      check({nm, ".hold_hilo"}, {hi, lo}, r);
    end
    ex_advance = 1'b1;
    @(negedge clk);
    ex_advance = 1'b0; op_valid = 1'b0;
    #1;
    check({nm, ".idle_after"}, 64'(res_valid), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] saved;
    rst = 1'b1; op_valid = 1'b0; op_in = 2'b00; src_a = '0; src_b = '0;
    flush = 1'b0; ex_advance = 1'b0; ready_force = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst.valid", 64'(res_valid), 64'd0);
    check("rst.hilo", {hi, lo}, 64'd0);
    check("rst.err", 64'(err_timeout), 64'd0);
    check("rst.start", 64'(div_start), 64'd0);
    check("rst.annul", 64'(div_annul), 64'd0);
    rst = 1'b0;

    do_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 1000, 3, ML + 1, 0, 0);
    do_op("multu",    2'b01, 32'hFFFF_FFFD, 32'd7, 64'h0000_0006_FFFF_FFEB, 1000, 0, ML + 1, 0, 0);
    do_op("mult_rnd", 2'b00, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1000, 0, ML + 1, 0, 0);
    do_op("divu",     2'b11, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 0, 35, 33, 0);
    do_op("div_neg",  2'b10, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 10, 1, 12, 10, 0);
    do_op("div_zero", 2'b10, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 1000, 0, 1, 0, 0);
`ifdef MDU_FAST_DIV_EN
    do_op("div_m1",   2'b10, 32'd9, 32'hFFFF_FFFF, {32'd0, 32'hFFFF_FFF7}, 5, 0, 1, 0, 0);
`else
    do_op("div_m1",   2'b10, 32'd9, 32'hFFFF_FFFF, {32'd0, 32'hFFFF_FFF7}, 5, 0, 7, 5, 0);
`endif

    // Flush in the middle of a divide; a stray ready afterwards must be ignored
    saved = {hi, lo};
    div_delay = 1000;
    @(negedge clk);
    op_valid = 1'b1; op_in = 2'b10; src_a = 32'd1000; src_b = 32'd3;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush.annul", 64'(div_annul), 64'd1);
    check("flush.start", 64'(div_start), 64'd0);
    check("flush.stall", 64'(stallreq), 64'd0);
    @(negedge clk);
    flush = 1'b0; op_valid = 1'b0;
    #1;
    check("flush.annul_drop", 64'(div_annul), 64'd0);
    check("flush.valid", 64'(res_valid), 64'd0);
    check("flush.hilo", {hi, lo}, saved);
    @(negedge clk);
    ready_force = 1'b1;
    @(negedge clk);
    ready_force = 1'b0;
    #1;
    check("flush.late_ready_valid", 64'(res_valid), 64'd0);
    check("flush.late_ready_hilo", {hi, lo}, saved);

    // op_valid dropping during MUL_WAIT acts as a flush
    @(negedge clk);
    op_valid = 1'b1; op_in = 2'b00; src_a = 32'd3; src_b = 32'd4;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      check("drop.valid", 64'(res_valid), 64'd0);
    end
    check("drop.hilo", {hi, lo}, saved);

    // Divider never answers: forced abort after TO cycles
    check("tmo.err_before", 64'(err_timeout), 64'd0);
    do_op("timeout", 2'b11, 32'd77, 32'd5, 64'd0, 100000, 0, TO + 1, TO - 1, 1);
    check("tmo.err_sticky", 64'(err_timeout), 64'd1);

    // Reset in the middle of a divide
    div_delay = 1000;
    @(negedge clk);
    op_valid = 1'b1; op_in = 2'b11; src_a = 32'd50; src_b = 32'd6;
    repeat (5) @(negedge clk);
    #1;
    check("midrst.start_before", 64'(div_start), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("midrst.start", 64'(div_start), 64'd0);
    check("midrst.annul", 64'(div_annul), 64'd0);
    check("midrst.err", 64'(err_timeout), 64'd0);
    check("midrst.hilo", {hi, lo}, 64'd0);
    rst = 1'b0; op_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
